// File: rtl/rr_mux_n_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_n_pkg : shared types and width helper for the rr_mux_n slice.  Rev 1.0
// ---------------------------------------------------------------------------
package rr_mux_n_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Keeps select/channel-id fields at least one bit wide for degenerate N.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_n_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_n_if : N-channel valid/ready input bundle plus registered output.  Rev 1.0
// ---------------------------------------------------------------------------
interface rr_mux_n_if
  import rr_mux_n_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4
);
  localparam int SELW = sel_width(N);

  logic                 i_mode;
  logic [SELW-1:0]      i_sel;
  logic [N-1:0]         i_in_valid;
  logic [N*WIDTH-1:0]   i_in_data;
  logic [N-1:0]         o_in_ready;
  logic                 o_out_valid;
  logic [WIDTH-1:0]     o_out_data;
  logic [SELW-1:0]      o_out_ch;
  logic                 i_out_ready;

  modport master (
    output i_mode, i_sel, i_in_valid, i_in_data, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_data, o_out_ch
  );

  modport slave (
    input  i_mode, i_sel, i_in_valid, i_in_data, i_out_ready,
    output o_in_ready, o_out_valid, o_out_data, o_out_ch
  );

endinterface
`default_nettype wire

// File: rtl/rr_mux_n_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter_n : combinational rotate-priority search starting after i_last.  Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter_n
  import rr_mux_n_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_last,
  output logic [N-1:0]    o_gnt,
  output logic [SELW-1:0] o_gnt_idx
);

  logic [SELW-1:0] w_pos;
  logic            w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = SELW'((int'(i_last) + 1 + k) % N);
      if (!w_found && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        o_gnt_idx    = w_pos;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_mux_n : N:1 registered valid/ready mux, explicit-select or round-robin.  Rev 1.0
// ---------------------------------------------------------------------------
module rr_mux_n
  import rr_mux_n_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int SELW  = sel_width(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_mux_n_if.slave   bus
);

  mux_mode_e        w_mode;
  logic             w_load;
  logic [N-1:0]     w_rr_gnt;
  logic [SELW-1:0]  w_rr_idx;
  logic [N-1:0]     w_sel_gnt;
  logic [N-1:0]     w_gnt;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic [SELW-1:0]  r_last;

  assign w_mode = mux_mode_e'(bus.i_mode);
  assign w_load = !r_out_valid || bus.i_out_ready;

  rr_arbiter_n #(.N(N)) u_arb (
    .i_req     (bus.i_in_valid),
    .i_last    (r_last),
    .o_gnt     (w_rr_gnt),
    .o_gnt_idx (w_rr_idx)
  );

  // Compare against every legal index so an out-of-range sel simply matches nothing.
  always_comb begin
    w_sel_gnt = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_gnt[i] = bus.i_in_valid[i] && (bus.i_sel == SELW'(i));
    end
  end

  assign w_gnt     = (w_mode == MODE_RR) ? w_rr_gnt : w_sel_gnt;
  assign w_gnt_idx = (w_mode == MODE_RR) ? w_rr_idx : bus.i_sel;

  assign bus.o_in_ready = (rst_n && w_load) ? w_gnt : '0;
  assign w_xfer         = |bus.o_in_ready;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_data = bus.i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_last      <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_gnt_idx;
      if (w_mode == MODE_RR) begin
        r_last <= w_gnt_idx;
      end
    end else if (bus.i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_data  = r_out_data;
  assign bus.o_out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_mux_n : scoreboard bench for rr_mux_n (N=4 main instance, N=6 select corner).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_rr_mux_n;
  import rr_mux_n_pkg::*;

  localparam int W4 = 64;
  localparam int N4 = 4;
  localparam int W6 = 8;
  localparam int N6 = 6;

  typedef struct {
    int            ch;
    logic [W4-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_last4 = N4 - 1;
  bit   m_ov4   = 1'b0;
  exp_t q4[$];

  always #5 clk = ~clk;

  rr_mux_n_if #(.WIDTH(W4), .N(N4)) b4 ();
  rr_mux_n_if #(.WIDTH(W6), .N(N6)) b6 ();

  rr_mux_n #(.WIDTH(W4), .N(N4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  rr_mux_n #(.WIDTH(W6), .N(N6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  function automatic int rr_pick(input logic [N4-1:0] v, input int last);
    for (int k = 0; k < N4; k++) begin
      int i;
      i = (last + 1 + k) % N4;
      if (((v >> i) & 4'b0001) != 4'b0000) return i;
    end
    return -1;
  endfunction

  // Reference grant and in_ready for the current inputs and model state.
  function automatic logic [N4-1:0] calc4(output int g);
    g = -1;
    if (b4.i_mode) g = rr_pick(b4.i_in_valid, m_last4);
    else if (b4.i_in_valid[b4.i_sel]) g = int'(b4.i_sel);
    return ((!m_ov4 || b4.i_out_ready) && g >= 0) ? (4'b0001 << g) : 4'b0000;
  endfunction

  task automatic adv4(input int g, input logic [N4-1:0] er);
    if (er != 4'b0000) begin
      q4.push_back('{ch: g, data: 64'hA0 + 64'(g)});
      m_ov4 = 1'b1;
      if (b4.i_mode) m_last4 = g;
    end else if (b4.i_out_ready) begin
      m_ov4 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N4-1:0] er;
    int            g;
    exp_t          e;
    rst_n = 1'b0;
    b4.i_mode = 1'b1; b4.i_sel = '0; b4.i_in_valid = 4'b1111; b4.i_out_ready = 1'b1;
    b4.i_in_data = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    b6.i_mode = 1'b0; b6.i_sel = '0; b6.i_in_valid = 6'b000000; b6.i_out_ready = 1'b1;
    b6.i_in_data = {8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (b4.o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", b4.o_out_valid); end
    n_chk++; if (b4.o_out_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", b4.o_out_data); end
    n_chk++; if (b4.o_out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", b4.o_out_ch); end
    n_chk++; if (b4.o_in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", b4.o_in_ready); end
    n_chk++; if (b6.o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid6: got %b want 0", b6.o_out_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1; m_last4 = N4 - 1; m_ov4 = 1'b0; q4.delete();
    #1;
    er = calc4(g);
    n_chk++; if (b4.o_in_ready !== er) begin n_err++; $display("FAIL release_ready: got %b want %b", b4.o_in_ready, er); end
    adv4(g, er);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      n_chk++;
      if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'(e.ch), e.data}) begin
        n_err++; $display("FAIL release_out: got v=%b ch=%0d d=%h want ch=%0d d=%h", b4.o_out_valid, b4.o_out_ch, b4.o_out_data, e.ch, e.data);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N4-1:0] er;
    int            g;
    exp_t          e;
    int            seq [5] = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      er = calc4(g);
      n_chk++; if (b4.o_in_ready !== er) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, b4.o_in_ready, er); end
      adv4(g, er);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        n_chk++;
        if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'(e.ch), e.data}) begin
          n_err++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h want ch=%0d d=%h", k, b4.o_out_valid, b4.o_out_ch, b4.o_out_data, e.ch, e.data);
        end
      end
      n_chk++; if (int'(b4.o_out_ch) !== seq[k]) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, b4.o_out_ch, seq[k]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [N4-1:0] er;
    int            g;
    exp_t          e;
    er = calc4(g);
    adv4(g, er);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      n_chk++;
      if ({b4.o_out_ch, b4.o_out_data} !== {2'(e.ch), e.data}) begin
        n_err++; $display("FAIL bp_load: got ch=%0d d=%h want ch=%0d d=%h", b4.o_out_ch, b4.o_out_data, e.ch, e.data);
      end
    end
    b4.i_out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      er = calc4(g);
      n_chk++; if (b4.o_in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, b4.o_in_ready); end
      adv4(g, er);
      n_chk++;
      if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'd2, 64'hA2}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=2 d=a2", k, b4.o_out_valid, b4.o_out_ch, b4.o_out_data);
      end
    end
    b4.i_out_ready = 1'b1;
    #1;
    er = calc4(g);
    n_chk++; if (b4.o_in_ready !== 4'b1000) begin n_err++; $display("FAIL bp_resume_ready: got %b want 1000", b4.o_in_ready); end
    adv4(g, er);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      n_chk++;
      if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'(e.ch), e.data}) begin
        n_err++; $display("FAIL bp_resume_out: got v=%b ch=%0d d=%h want ch=%0d d=%h", b4.o_out_valid, b4.o_out_ch, b4.o_out_data, e.ch, e.data);
      end
    end
  endtask

  task automatic test_select();
    logic [N4-1:0] er;
    int            g;
    exp_t          e;
    b4.i_mode = 1'b0; b4.i_sel = 2'd2; b4.i_in_valid = 4'b1010;
    #1;
    er = calc4(g);
    n_chk++; if (b4.o_in_ready !== 4'b0000) begin n_err++; $display("FAIL sel_nogrant: got %b want 0000", b4.o_in_ready); end
    adv4(g, er);
    n_chk++; if (b4.o_out_valid !== 1'b0) begin n_err++; $display("FAIL sel_drain: got %b want 0", b4.o_out_valid); end
    b4.i_in_valid = 4'b0100;
    #1;
    er = calc4(g);
    n_chk++; if (b4.o_in_ready !== er) begin n_err++; $display("FAIL sel_ready: got %b want %b", b4.o_in_ready, er); end
    adv4(g, er);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      n_chk++;
      if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'(e.ch), e.data}) begin
        n_err++; $display("FAIL sel_out: got v=%b ch=%0d d=%h want ch=%0d d=%h", b4.o_out_valid, b4.o_out_ch, b4.o_out_data, e.ch, e.data);
      end
    end
    b6.i_sel = 3'd5; b6.i_in_valid = 6'b100000;
    #1;
    n_chk++; if (b6.o_in_ready !== 6'b100000) begin n_err++; $display("FAIL sel6_ready5: got %b want 100000", b6.o_in_ready); end
    @(posedge clk);
    #1;
    n_chk++;
    if ({b6.o_out_valid, b6.o_out_ch, b6.o_out_data} !== {1'b1, 3'd5, 8'hB5}) begin
      n_err++; $display("FAIL sel6_out5: got v=%b ch=%0d d=%h want v=1 ch=5 d=b5", b6.o_out_valid, b6.o_out_ch, b6.o_out_data);
    end
    b6.i_sel = 3'd7; b6.i_in_valid = 6'b111111;
    #1;
    n_chk++; if (b6.o_in_ready !== 6'b000000) begin n_err++; $display("FAIL sel6_ready7: got %b want 000000", b6.o_in_ready); end
    @(posedge clk);
    #1;
    n_chk++; if (b6.o_out_valid !== 1'b0) begin n_err++; $display("FAIL sel6_out7: got v=%b want 0", b6.o_out_valid); end
    b6.i_in_valid = 6'b000000;
  endtask

  task automatic test_mode_switch();
    logic [N4-1:0] er;
    int            g;
    exp_t          e;
    b4.i_mode = 1'b1; b4.i_in_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin b4.i_mode = 1'b0; b4.i_sel = 2'd3; b4.i_in_valid = 4'b1000; end
      if (k == 3) begin b4.i_mode = 1'b1; b4.i_in_valid = 4'b1111; end
      #1;
      er = calc4(g);
      n_chk++; if (b4.o_in_ready !== er) begin n_err++; $display("FAIL ms_ready[%0d]: got %b want %b", k, b4.o_in_ready, er); end
      adv4(g, er);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        n_chk++;
        if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'(e.ch), e.data}) begin
          n_err++; $display("FAIL ms_out[%0d]: got v=%b ch=%0d d=%h want ch=%0d d=%h", k, b4.o_out_valid, b4.o_out_ch, b4.o_out_data, e.ch, e.data);
        end
      end
    end
    n_chk++; if (b4.o_out_ch !== 2'd2) begin n_err++; $display("FAIL ms_resume_ch: got %0d want 2", b4.o_out_ch); end
  endtask

  task automatic test_async_reset();
    logic [N4-1:0] er;
    int            g;
    exp_t          e;
    n_chk++; if (b4.o_out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid: got %b want 1", b4.o_out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (b4.o_out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid_now: got %b want 0", b4.o_out_valid); end
    n_chk++; if (b4.o_in_ready !== 4'b0000) begin n_err++; $display("FAIL ar_ready: got %b want 0000", b4.o_in_ready); end
    m_last4 = N4 - 1; m_ov4 = 1'b0; q4.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    er = calc4(g);
    n_chk++; if (b4.o_in_ready !== 4'b0001) begin n_err++; $display("FAIL ar_restart_ready: got %b want 0001", b4.o_in_ready); end
    adv4(g, er);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      n_chk++;
      if ({b4.o_out_valid, b4.o_out_ch, b4.o_out_data} !== {1'b1, 2'(e.ch), e.data}) begin
        n_err++; $display("FAIL ar_restart_out: got v=%b ch=%0d d=%h want ch=%0d d=%h", b4.o_out_valid, b4.o_out_ch, b4.o_out_data, e.ch, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_select();
    test_mode_switch();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
